// File: rtl/uart_apb_rx.sv
// APB-attached UART receiver: 2-flop RXD synchroniser, 16x oversampling frame FSM, receive FIFO, sticky line status.
// Optional parity checking is built when the macro UART_RX_PARITY_EN is defined.
module uart_apb_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        RXD,
  output logic        IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_next;

  logic [15:0] div, div_cnt, div_eff;
  logic [4:0]  lcr;
  logic        tick;
  logic        rxd_s1, rxd_s2, line_d, line, fall;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt, last_bit;
  logic [7:0]  shreg;
  logic        cnt_clr, data_smp, par_smp, stop_smp;
  logic        oe, pe, fe, oe_set, pe_set, fe_set;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        empty, full, push, pop;
  logic        access, rd, wr, sel_rbr, sel_div, sel_lcr, sel_lsr, addr_ok;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[31:8], PWDATA[31:16]};

  assign access  = PSEL & PENABLE;
  assign rd      = access & ~PWRITE;
  assign wr      = access & PWRITE;
  assign sel_rbr = (PADDR[7:0] == 8'h00);
  assign sel_div = (PADDR[7:0] == 8'h04);
  assign sel_lcr = (PADDR[7:0] == 8'h0C);
  assign sel_lsr = (PADDR[7:0] == 8'h14);
  assign addr_ok = sel_rbr | sel_div | sel_lcr | sel_lsr;
  assign PREADY  = 1'b1;
  assign PSLVERR = access & ~addr_ok;

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      div <= 16'h0001;
      lcr <= 5'h03;
    end else if (wr) begin
      if (sel_div) div <= PWDATA[15:0];
      if (sel_lcr) lcr <= PWDATA[4:0];
    end
  end

  // Oversample tick generator; a DIV write realigns the tick phase.
  assign div_eff = (div == 16'd0) ? 16'd1 : div;
  assign tick    = (div_cnt == div_eff - 16'd1);

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn)                div_cnt <= 16'd0;
    else if ((wr && sel_div) || tick) div_cnt <= 16'd0;
    else                         div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      line_d <= 1'b1;
    end else begin
      rxd_s1 <= RXD;
      rxd_s2 <= rxd_s1;
      line_d <= rxd_s2;
    end
  end

  assign line     = rxd_s2;
  assign fall     = line_d & ~line;
  assign last_bit = 3'd4 + {1'b0, lcr[1:0]};

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    data_smp   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_next = START;
        cnt_clr    = 1'b1;
      end
      START: if (tick && tick_cnt == 4'd7) begin
        cnt_clr    = 1'b1;
        state_next = line ? IDLE : DATA;
      end
      DATA: if (tick && tick_cnt == 4'd15) begin
        data_smp = 1'b1;
        if (bit_cnt == last_bit) begin
          cnt_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
          state_next = lcr[3] ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && tick_cnt == 4'd15) begin
        par_smp    = 1'b1;
        cnt_clr    = 1'b1;
        state_next = STOP;
      end
`endif
      STOP: if (tick && tick_cnt == 4'd15) begin
        stop_smp   = 1'b1;
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else if (cnt_clr) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else if (tick && state != IDLE) begin
      tick_cnt <= tick_cnt + 4'd1;
      if (data_smp) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Shift register is cleared on DATA entry so short words come out zero-extended.
  always_ff @(posedge clock) begin
    if (state == START && state_next == DATA) shreg <= 8'd0;
    else if (data_smp)                        shreg[bit_cnt] <= line;
  end

`ifdef UART_RX_PARITY_EN
  assign pe_set = par_smp & (lcr[4] ? (^shreg ^ line) : ~(^shreg ^ line));
`else
  assign pe_set = par_smp & 1'b0;
`endif
  assign fe_set = stop_smp & ~line;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign pop    = rd & sel_rbr & ~empty;
  assign push   = stop_smp & (~full | pop);
  assign oe_set = stop_smp & full & ~pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Error flags clear on an LSR read unless a new error lands in that same cycle.
  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      oe  <= 1'b0;
      pe  <= 1'b0;
      fe  <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      oe  <= (oe & ~(rd & sel_lsr)) | oe_set;
      pe  <= (pe & ~(rd & sel_lsr)) | pe_set;
      fe  <= (fe & ~(rd & sel_lsr)) | fe_set;
      IRQ <= ~empty | oe | pe | fe;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_rbr)      rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
    else if (sel_div) rdata = {16'd0, div};
    else if (sel_lcr) rdata = {27'd0, lcr};
    else if (sel_lsr) rdata = {27'd0, full, fe, pe, oe, ~empty};
  end

  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn)  PRDATA <= 32'd0;
    else if (rd)   PRDATA <= rdata;
  end

endmodule

// File: tb/tb_uart_apb_rx.sv
// Scoreboard bench for uart_apb_rx: frames are serialised on RXD, expected characters queued and
// compared on RBR reads; status, IRQ and APB error responses are checked inline per scenario.
module tb_uart_apb_rx;

  logic        clock = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        RXD;
  logic        IRQ;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd, exp;
  logic        err;

  uart_apb_rx #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RXD(RXD), .IRQ(IRQ)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge clock);
    PADDR = {24'd0, a}; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clock);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge clock);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge clock);
    PADDR = {24'd0, a}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clock);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge clock);
    #1 d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input int cpb, input bit has_par,
                            input bit pbit, input bit stopb, input bit store);
    logic [7:0] m;
    m = 8'((1 << nbits) - 1);
    if (store) exp_q.push_back(d & m);
    @(negedge clock);
    RXD = 1'b0;
    repeat (cpb) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      RXD = d[i];
      repeat (cpb) @(negedge clock);
    end
    if (has_par) begin
      RXD = pbit;
      repeat (cpb) @(negedge clock);
    end
    RXD = stopb;
    repeat (cpb) @(negedge clock);
    RXD = 1'b1;
    repeat (cpb) @(negedge clock);
  endtask

  task automatic test_reset;
    PRESETn = 1'b0; RXD = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0;
    #1;
    n_cmp++; if (PRDATA !== 32'd0) begin n_fail++; $display("FAIL reset_prdata got %h want 0", PRDATA); end
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", IRQ); end
    n_cmp++; if (PSLVERR !== 1'b0 || PREADY !== 1'b1) begin n_fail++; $display("FAIL reset_resp slverr %b ready %b want 0/1", PSLVERR, PREADY); end
    repeat (3) @(negedge clock);
    PRESETn = 1'b1;
    repeat (4) @(negedge clock);
    apb_read(8'h04, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL reset_div got %h want 1", rd); end
    apb_read(8'h0C, rd, err);
    n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_lcr got %h want 3", rd); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_lsr got %h want 0", rd); end
  endtask

  task automatic test_basic;
    apb_write(8'h04, 32'h1, err);
    apb_write(8'h0C, 32'h3, err);
    send_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL basic_irq got %b want 1", IRQ); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h01) begin n_fail++; $display("FAIL basic_lsr got %h want 01", rd); end
    apb_read(8'h00, rd, err);
    exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL basic_rbr got %h want %h", rd, exp); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h00) begin n_fail++; $display("FAIL basic_lsr_after got %h want 00", rd); end
    repeat (2) @(negedge clock);
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL basic_irq_clear got %b want 0", IRQ); end
  endtask

  task automatic test_false_start;
    @(negedge clock);
    RXD = 1'b0;
    repeat (4) @(negedge clock);
    RXD = 1'b1;
    repeat (40) @(negedge clock);
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h00) begin n_fail++; $display("FAIL glitch_lsr got %h want 00", rd); end
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got %b want 0", IRQ); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 5; i++)
      send_frame(8'h11 + 8'(i), 8, 16, 1'b0, 1'b0, 1'b1, (i < 4));
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h13) begin n_fail++; $display("FAIL ovr_lsr got %h want 13", rd); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h11) begin n_fail++; $display("FAIL ovr_lsr_clear got %h want 11", rd); end
    for (int i = 0; i < 4; i++) begin
      apb_read(8'h00, rd, err);
      exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
      n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL ovr_rbr%0d got %h want %h", i, rd, exp); end
    end
    apb_read(8'h00, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL empty_rbr got %h want 0", rd); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h00) begin n_fail++; $display("FAIL ovr_lsr_end got %h want 00", rd); end
  endtask

  task automatic test_word_len;
    apb_write(8'h0C, 32'h0, err);
    send_frame(8'h15, 5, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    apb_write(8'h0C, 32'h2, err);
    send_frame(8'h55, 7, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      apb_read(8'h00, rd, err);
      exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
      n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL wlen_rbr%0d got %h want %h", i, rd, exp); end
    end
    apb_write(8'h0C, 32'h3, err);
  endtask

  task automatic test_parity;
    apb_write(8'h0C, 32'h1B, err);
    send_frame(8'h07, 8, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    apb_read(8'h14, rd, err);
`ifdef UART_RX_PARITY_EN
    exp = 32'h05;
`else
    exp = 32'h09;  // no parity stage: the stop sample lands on the low parity bit
`endif
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL par_lsr got %h want %h", rd, exp); end
    apb_read(8'h00, rd, err);
    exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL par_rbr got %h want %h", rd, exp); end
`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 8, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h01) begin n_fail++; $display("FAIL par_ok_lsr got %h want 01", rd); end
    apb_read(8'h00, rd, err);
    exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL par_ok_rbr got %h want %h", rd, exp); end
`endif
    apb_write(8'h0C, 32'h3, err);
    apb_read(8'h0C, rd, err);
    n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL lcr_rw got %h want 3", rd); end
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 8, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    apb_read(8'h00, rd, err);
    exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL fe_rbr got %h want %h", rd, exp); end
    repeat (2) @(negedge clock);
    n_cmp++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL fe_irq got %b want 1", IRQ); end
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h08) begin n_fail++; $display("FAIL fe_lsr got %h want 08", rd); end
    repeat (2) @(negedge clock);
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL fe_irq_clear got %b want 0", IRQ); end
    apb_read(8'h20, rd, err);
    n_cmp++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL bad_addr_rd slverr %b data %h want 1/0", err, rd); end
    apb_write(8'h20, 32'hFFFF, err);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_addr_wr slverr %b want 1", err); end
    apb_write(8'h00, 32'h55, err);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rbr_wr slverr %b want 0", err); end
    apb_read(8'h04, rd, err);
    n_cmp++; if (rd !== 32'h1 || err !== 1'b0) begin n_fail++; $display("FAIL div_kept got %h/%b want 1/0", rd, err); end
  endtask

  task automatic test_divider;
    apb_write(8'h04, 32'h2, err);
    send_frame(8'hC3, 8, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    apb_write(8'h04, 32'h0, err);
    apb_read(8'h04, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL div0_rd got %h want 0", rd); end
    send_frame(8'h96, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      apb_read(8'h00, rd, err);
      exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
      n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL div_rbr%0d got %h want %h", i, rd, exp); end
    end
    apb_write(8'h04, 32'h1, err);
  endtask

  task automatic test_mid_reset;
    send_frame(8'h77, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    RXD = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      RXD = i[0];
      repeat (16) @(negedge clock);
    end
    PRESETn = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL mrst_irq got %b want 0", IRQ); end
    repeat (3) @(negedge clock);
    RXD = 1'b1;
    PRESETn = 1'b1;
    repeat (40) @(negedge clock);
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h00) begin n_fail++; $display("FAIL mrst_lsr got %h want 00", rd); end
    apb_read(8'h00, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mrst_rbr_empty got %h want 0", rd); end
    send_frame(8'h5A, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    apb_read(8'h14, rd, err);
    n_cmp++; if (rd !== 32'h01) begin n_fail++; $display("FAIL mrst_lsr2 got %h want 01", rd); end
    apb_read(8'h00, rd, err);
    exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEADBEEF;
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL mrst_rbr got %h want %h", rd, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_overrun();
    test_word_len();
    test_parity();
    test_framing();
    test_divider();
    test_mid_reset();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_rx.md
UART_APB_RX -- requirements
Module: uart_apb_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port PRESETn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports PADDR input 32, PWDATA input 32, PWRITE input 1, PSEL input 1, PENABLE input 1: APB requester signals.
REQ-005 SHALL have ports PRDATA output 32, PREADY output 1, PSLVERR output 1: APB completer response.
REQ-006 SHALL have port RXD  input  1  serial receive line, idle high, asynchronous to clock.
REQ-007 SHALL have port IRQ  output  1  level interrupt request.

Function
REQ-008 SHALL tie PREADY to 1 (zero wait states); a transfer completes on the cycle PSEL=PENABLE=1.
REQ-009 SHALL decode PADDR[7:0]: 0x00 RBR (RO), 0x04 DIV (RW, bits[15:0]), 0x0C LCR (RW, bits[4:0]), 0x14 LSR (RO); other offsets drive PSLVERR=1 in the access cycle, PRDATA=0, no state change.
REQ-010 SHALL ignore writes to RBR/LSR with PSLVERR=0; unused read bits return 0.
REQ-011 SHALL register PRDATA in the access cycle and hold it until the next read access.
REQ-012 SHALL synchronise RXD through two flops before use; line state below refers to the synchronised value.
REQ-013 SHALL generate a 16x oversample tick every DIV clocks; DIV=0 treated as 1; a DIV write restarts the tick counter.
REQ-014 SHALL use LCR[1:0] = word length 5+value bits, LCR[3] = parity enable, LCR[4] = even parity select, LCR[2] = reserved read/write.
REQ-015 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; tick counter and bit counter reset on each state entry.
REQ-016 IDLE->START on a 1->0 line transition; START samples line at 8th tick: low -> DATA, high -> IDLE (false start, nothing recorded).
REQ-017 DATA samples one bit per 16 ticks, LSB first, word-length bits; then PARITY if enabled, else STOP.
REQ-018 PARITY samples one bit after 16 ticks; mismatch against data (even: total ones even) sets LSR.PE.
REQ-019 STOP samples after 16 ticks; low sets LSR.FE; in both cases the character is pushed and FSM returns to IDLE the next cycle.
REQ-020 SHALL push characters zero-extended to 8 bits; push into full FIFO discards the character and sets LSR.OE.
REQ-021 RBR read pops FIFO head (PRDATA = head); RBR read when empty returns 0, no pop.
REQ-022 Push and pop in same cycle with FIFO full SHALL both succeed, no OE; with FIFO empty the pop returns 0 and the push is stored.
REQ-023 LSR bits: [0] DR = FIFO non-empty, [1] OE, [2] PE, [3] FE, [4] FIFO full; OE/PE/FE sticky, cleared by LSR read (an error arising in the same cycle stays set).
REQ-024 IRQ SHALL be DR | OE | PE | FE, registered, one cycle after the causing state change.

Reset
REQ-025 On PRESETn low SHALL immediately: FSM IDLE, FIFO empty, DIV=0x0001, LCR=0x03 (8N1), LSR errors 0, PRDATA=0, PSLVERR=0, IRQ=0, synchroniser flops 1; a partial frame is lost.
REQ-026 After PRESETn rises SHALL require the line high (sync output 1) before detecting a start bit.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state and LSR.PE implemented per REQ-018.
REQ-028 Macro UART_RX_PARITY_EN undefined: PARITY state absent, LCR[4:3] read/write but ignored, LSR.PE constant 0, frame always DATA->STOP.

Verification
REQ-029 DIV=1, LCR=0x03, RXD frame 0xA5 8N1 (16 clocks/bit) -> IRQ=1, LSR=0x01, RBR read 0xA5, then LSR=0x00, IRQ=0.
REQ-030 Low pulse of 4 clocks on idle RXD -> no push, LSR=0x00.
REQ-031 FIFO_DEPTH=4, send 5 frames 0x11..0x15 without reading -> LSR=0x13, reads return 0x11..0x14, OE cleared by the LSR read.
REQ-032 LCR=0x1B (8E1, macro defined), frame 0x07 with parity bit 0 -> LSR.PE=1, RBR=0x07; macro undefined -> LSR.PE=0.
REQ-033 Frame 0x3C with stop bit low -> LSR.FE=1, RBR=0x3C; access to PADDR 0x20 -> PSLVERR=1, PRDATA=0.
REQ-034 PRESETn pulsed low mid-DATA of a frame -> FIFO empty, LSR=0x00, next full frame 0x5A received correctly.
